// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
package uart_pkg;

    // Receiver frame sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam int PARITY_NONE   = 0;
    localparam int PARITY_EVEN   = 1;
    localparam int PARITY_ODD    = 2;

    // Widest legal data word; narrower words are zero-extended before use.
    localparam int MAX_DATA_BITS = 9;

    // Expected parity bit for a data word: XOR of the bits, inverted for odd.
    function automatic logic parity_calc(input logic [MAX_DATA_BITS-1:0] data,
                                         input int                       mode);
        return (^data) ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Input conditioning for the UART receiver: a 2-flop synchroniser on the
// asynchronous rx line and a 3-sample majority vote around mid-bit.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = $clog2(OVERSAMPLE)
) (
    input  logic             s_tick,
    input  logic             reset,
    input  logic             rx,
    input  logic [CNT_W-1:0] cnt,
    output logic             rx_s,
    output logic             vote
);
    localparam int M = OVERSAMPLE / 2;
    localparam logic [CNT_W-1:0] CNT_V0 = CNT_W'(M - 1);
    localparam logic [CNT_W-1:0] CNT_V1 = CNT_W'(M);
    localparam logic [CNT_W-1:0] CNT_V2 = CNT_W'(M + 1);

    logic rx_meta;
    logic s0, s1, s2;
    logic s2_live;

    // Two-stage synchroniser; presets to the idle-high line level.
    always_ff @(posedge s_tick) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Capture the three vote samples at M-1, M and M+1 of each bit.
    always_ff @(posedge s_tick) begin
        if (!reset) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            if (cnt == CNT_V0) s0 <= rx_s;
            if (cnt == CNT_V1) s1 <= rx_s;
            if (cnt == CNT_V2) s2 <= rx_s;
        end
    end

    // Majority of the three samples; at M+1 the third sample is taken live
    // so the decision is usable in the same tick.
    always_comb begin
        s2_live = (cnt == CNT_V2) ? rx_s : s2;
        vote    = (s0 & s1) | (s0 & s2_live) | (s1 & s2_live);
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority voting, false-start rejection,
// parity/frame/overrun reporting and a one-entry valid/ready output buffer.
// Optional break detection is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 s_tick,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
`ifdef UART_RX_BREAK_DET_EN
    ,
    output logic                 break_det
`endif
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam int M     = OVERSAMPLE / 2;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(M + 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_BITS - 1);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     idx;
    logic [DATA_BITS-1:0] shift;
    logic                 stop_idx;
    logic                 perr_q, ferr_q;
    logic                 done_q;
    logic                 rx_s, vote;
    logic                 bit_end, decide, last_stop, frame_end;
    logic                 brk_q, hold;

    uart_rx_sampler #(
        .OVERSAMPLE(OVERSAMPLE),
        .CNT_W     (CNT_W)
    ) u_sampler (
        .s_tick(s_tick),
        .reset (reset),
        .rx    (rx),
        .cnt   (cnt),
        .rx_s  (rx_s),
        .vote  (vote)
    );

    assign bit_end   = (cnt == CNT_LAST);
    assign decide    = (cnt == CNT_DECIDE);
    assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
    // The final stop bit completes at its mid-bit vote to allow resync.
    assign frame_end = (state == STOP) && decide && last_stop;

    // State register.
    always_ff @(posedge s_tick) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic for the frame sequencer.
    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE:    if (!hold && !rx_s) state_next = START;
            START:   if (decide && vote) state_next = IDLE;
                     else if (bit_end)   state_next = DATA;
            DATA:    if (bit_end && idx == IDX_LAST) begin
                         if (PARITY_MODE != PARITY_NONE) state_next = PARITY;
                         else                            state_next = STOP;
                     end
            PARITY:  if (bit_end)   state_next = STOP;
            STOP:    if (frame_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit timing, data shift-in and per-frame error accumulation.
    always_ff @(posedge s_tick) begin
        // NOTE: the data shift register is reset too, so a reset mid-frame leaves no stale bits.
        if (!reset) begin
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
            stop_idx <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= frame_end;

            if (state_next != state) begin
                cnt <= '0;
            end else if (state == IDLE) begin
                // While holding off after a break, count consecutive idle-high ticks.
                if (hold && rx_s && cnt != CNT_LAST) cnt <= cnt + CNT_W'(1);
                else                                 cnt <= '0;
            end else begin
                cnt <= bit_end ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                IDLE: if (state_next == START) begin
                    perr_q   <= 1'b0;
                    ferr_q   <= 1'b0;
                    stop_idx <= 1'b0;
                end
                START: if (state_next == DATA) idx <= '0;
                DATA: if (bit_end) begin
                    shift[idx] <= vote;
                    idx        <= idx + IDX_W'(1);
                end
                PARITY: if (bit_end) begin
                    perr_q <= vote ^ parity_calc(MAX_DATA_BITS'(shift), PARITY_MODE);
                end
                STOP: if (frame_end) begin
                    ferr_q <= ferr_q | ~vote;
                end else if (bit_end) begin
                    ferr_q   <= ferr_q | ~vote;
                    stop_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // One-entry output buffer: load on completion if free or being drained,
    // otherwise drop the frame and flag an overrun.
    always_ff @(posedge s_tick) begin
        if (!reset) begin
            dout        <= '0;
            dout_valid  <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done_q && !brk_q) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= shift;
                    parity_err <= perr_q;
                    frame_err  <= ferr_q;
                    dout_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic par_bit;
    logic is_break;

    assign is_break = frame_end && (shift == '0) && !par_bit && !vote;

    // Remember the received parity bit; a break needs it to be 0 as well.
    always_ff @(posedge s_tick) begin
        if (!reset) begin
            par_bit <= 1'b0;
        end else if (state == IDLE && state_next == START) begin
            par_bit <= 1'b0;
        end else if (state == PARITY && bit_end) begin
            par_bit <= vote;
        end
    end

    // Flag break frames and hold off start detection until the line idles high.
    always_ff @(posedge s_tick) begin
        if (!reset) begin
            brk_q     <= 1'b0;
            hold      <= 1'b0;
            break_det <= 1'b0;
        end else begin
            brk_q     <= is_break;
            break_det <= done_q && brk_q;
            if (is_break)                                    hold <= 1'b1;
            else if (state == IDLE && rx_s && cnt == CNT_LAST) hold <= 1'b0;
        end
    end
`else
    assign brk_q = 1'b0;
    assign hold  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: four receivers (8N1, 8E1, 8O1, 8N2)
// driven by table vectors plus hand-written multi-cycle sequences.
module tb_uart_rx_param;

    localparam int OS = 16;

    logic       s_tick = 1'b0;
    logic       reset;
    logic       rx_w    [4];
    logic       ready_w [4];
    logic [7:0] dout_w  [4];
    logic       dv_w    [4];
    logic       pe_w    [4];
    logic       fe_w    [4];
    logic       ov_w    [4];
`ifdef UART_RX_BREAK_DET_EN
    logic       bd_w    [4];
`endif

    int         checks   = 0;
    int         failures = 0;

    // Monitor state: valid-high cycles, accepted words, overrun/break pulses.
    int         vcyc [4] = '{0, 0, 0, 0};
    int         acc  [4] = '{0, 0, 0, 0};
    int         ovc  [4] = '{0, 0, 0, 0};
    int         bdc  [4] = '{0, 0, 0, 0};
    logic [7:0] last_d  [4];
    logic       last_pe [4];
    logic       last_fe [4];

    always #5 s_tick = ~s_tick;

    uart_rx_param u_8n1 (
        .s_tick(s_tick), .reset(reset), .rx(rx_w[0]), .dout(dout_w[0]), .dout_valid(dv_w[0]),
        .dout_ready(ready_w[0]), .parity_err(pe_w[0]), .frame_err(fe_w[0]), .overrun_err(ov_w[0])
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(bd_w[0])
`endif
    );

    uart_rx_param #(.PARITY_MODE(1)) u_8e1 (
        .s_tick(s_tick), .reset(reset), .rx(rx_w[1]), .dout(dout_w[1]), .dout_valid(dv_w[1]),
        .dout_ready(ready_w[1]), .parity_err(pe_w[1]), .frame_err(fe_w[1]), .overrun_err(ov_w[1])
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(bd_w[1])
`endif
    );

    uart_rx_param #(.PARITY_MODE(2)) u_8o1 (
        .s_tick(s_tick), .reset(reset), .rx(rx_w[2]), .dout(dout_w[2]), .dout_valid(dv_w[2]),
        .dout_ready(ready_w[2]), .parity_err(pe_w[2]), .frame_err(fe_w[2]), .overrun_err(ov_w[2])
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(bd_w[2])
`endif
    );

    uart_rx_param #(.STOP_BITS(2)) u_8n2 (
        .s_tick(s_tick), .reset(reset), .rx(rx_w[3]), .dout(dout_w[3]), .dout_valid(dv_w[3]),
        .dout_ready(ready_w[3]), .parity_err(pe_w[3]), .frame_err(fe_w[3]), .overrun_err(ov_w[3])
`ifdef UART_RX_BREAK_DET_EN
        , .break_det(bd_w[3])
`endif
    );

    // Sample outputs mid-cycle; inputs change 2 time units after posedge.
    always @(negedge s_tick) begin
        for (int k = 0; k < 4; k++) begin
            if (dv_w[k]) vcyc[k] <= vcyc[k] + 1;
            if (ov_w[k]) ovc[k]  <= ovc[k] + 1;
`ifdef UART_RX_BREAK_DET_EN
            if (bd_w[k]) bdc[k]  <= bdc[k] + 1;
`endif
            if (dv_w[k] && ready_w[k]) begin
                acc[k]     <= acc[k] + 1;
                last_d[k]  <= dout_w[k];
                last_pe[k] <= pe_w[k];
                last_fe[k] <= fe_w[k];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge s_tick);
            #2;
        end
    endtask

    // Drive one frame on receiver sel; optional 1-tick low glitch at (gbit, gtick).
    task automatic send_frame(input int sel, input logic [7:0] data, input logic par,
                              input logic stop1, input logic stop2,
                              input int gbit, input int gtick);
        logic bits [12];
        int   n;
        n = 0;
        bits[n] = 1'b0; n++;
        for (int i = 0; i < 8; i++) begin
            bits[n] = data[i]; n++;
        end
        if (sel == 1 || sel == 2) begin
            bits[n] = par; n++;
        end
        bits[n] = stop1; n++;
        if (sel == 3) begin
            bits[n] = stop2; n++;
        end
        for (int b = 0; b < n; b++) begin
            for (int t = 0; t < OS; t++) begin
                rx_w[sel] = (b == gbit && t == gtick) ? 1'b0 : bits[b];
                step(1);
            end
        end
        rx_w[sel] = 1'b1;
    endtask

    typedef struct {
        int         sel;
        logic [7:0] data;
        logic       par;
        logic       stop1;
        logic       stop2;
        logic [7:0] exp_d;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int s, v0, a0, o0, b0;

        tbl[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        tbl[3] = '{1, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b1, 1'b0};  // even wants 1
        tbl[4] = '{1, 8'h07, 1'b1, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};
        tbl[5] = '{2, 8'h07, 1'b0, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0};  // odd wants 0
        tbl[6] = '{2, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0};  // odd wants 1
        tbl[7] = '{3, 8'h3C, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};  // 2nd stop low
        tbl[8] = '{3, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
        tbl[9] = '{0, 8'h01, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1};  // stop low

        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rx_w[k]    = 1'b1;
            ready_w[k] = 1'b1;
        end
        step(3);
        reset = 1'b1;
        step(2);

        check("rst_dout",    32'(dout_w[0]), 32'h0);
        check("rst_valid",   32'(dv_w[0]),   32'h0);
        check("rst_perr",    32'(pe_w[1]),   32'h0);
        check("rst_ferr",    32'(fe_w[3]),   32'h0);
        check("rst_overrun", 32'(ov_w[0]),   32'h0);

        // Table-driven frames across all four configurations.
        for (int i = 0; i < 10; i++) begin
            s  = tbl[i].sel;
            v0 = vcyc[s];
            send_frame(s, tbl[i].data, tbl[i].par, tbl[i].stop1, tbl[i].stop2, -1, 0);
            step(2 * OS);
            check($sformatf("vec%0d_valid_cycles", i), 32'(vcyc[s] - v0), 32'd1);
            check($sformatf("vec%0d_dout", i),         32'(last_d[s]),     32'(tbl[i].exp_d));
            check($sformatf("vec%0d_parity_err", i),   32'(last_pe[s]),    32'(tbl[i].exp_pe));
            check($sformatf("vec%0d_frame_err", i),    32'(last_fe[s]),    32'(tbl[i].exp_fe));
        end

        // Short low glitch is rejected as a false start.
        v0 = vcyc[0];
        rx_w[0] = 1'b0;
        step(4);
        rx_w[0] = 1'b1;
        step(3 * OS);
        check("false_start_no_word", 32'(vcyc[0] - v0), 32'd0);

        // Single-tick glitch at mid data bit 3 of 0xFF is outvoted.
        v0 = vcyc[0];
        send_frame(0, 8'hFF, 1'b0, 1'b1, 1'b1, 4, 9);
        step(2 * OS);
        check("glitch_word_count", 32'(vcyc[0] - v0), 32'd1);
        check("glitch_dout",       32'(last_d[0]),    32'hFF);

        // Overrun: consumer stalled, two back-to-back frames.
        ready_w[0] = 1'b0;
        o0 = ovc[0];
        send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, -1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, -1, 0);
        step(2 * OS);
        check("overrun_hold_valid", 32'(dv_w[0]),      32'd1);
        check("overrun_hold_dout",  32'(dout_w[0]),    32'h11);
        check("overrun_pulses",     32'(ovc[0] - o0),  32'd1);

        // Drain in the exact completion cycle of 0x33 (completion is sampled
        // 158 edges after the start bit is driven), then one more cycle.
        o0 = ovc[0];
        a0 = acc[0];
        fork
            send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, -1, 0);
            begin
                step(157);
                ready_w[0] = 1'b1;
                step(2);
                ready_w[0] = 1'b0;
            end
        join
        step(OS);
        check("drain_no_overrun", 32'(ovc[0] - o0), 32'd0);
        check("drain_accepts",    32'(acc[0] - a0), 32'd2);
        check("drain_last_dout",  32'(last_d[0]),   32'h33);
        check("drain_valid_low",  32'(dv_w[0]),     32'd0);
        ready_w[0] = 1'b1;

        // 8N2 frame error held, then reset mid-DATA of the next frame.
        send_frame(3, 8'h3C, 1'b0, 1'b1, 1'b0, -1, 0);
        step(2 * OS);
        check("n2_frame_err_held", 32'(fe_w[3]), 32'd1);
        rx_w[3] = 1'b0;
        step(OS);
        rx_w[3] = 1'b1;
        step(OS + 4);
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        check("midrst_dout",      32'(dout_w[3]), 32'h0);
        check("midrst_frame_err", 32'(fe_w[3]),   32'h0);
        check("midrst_valid",     32'(dv_w[3]),   32'h0);
        check("midrst_other_dout", 32'(dout_w[0]), 32'h0);
        step(2 * OS);
        a0 = acc[3];
        send_frame(3, 8'h5A, 1'b0, 1'b1, 1'b1, -1, 0);
        step(2 * OS);
        check("postrst_accepts",   32'(acc[3] - a0), 32'd1);
        check("postrst_dout",      32'(last_d[3]),   32'h5A);
        check("postrst_frame_err", 32'(last_fe[3]),  32'd0);

`ifdef UART_RX_BREAK_DET_EN
        // Line held low for 12 bit times is a break, not a word.
        v0 = vcyc[0];
        b0 = bdc[0];
        o0 = ovc[0];
        rx_w[0] = 1'b0;
        step(12 * OS);
        rx_w[0] = 1'b1;
        step(2 * OS);
        check("break_pulses",     32'(bdc[0] - b0), 32'd1);
        check("break_no_word",    32'(vcyc[0] - v0), 32'd0);
        check("break_no_overrun", 32'(ovc[0] - o0), 32'd0);
        a0 = acc[0];
        send_frame(0, 8'h81, 1'b0, 1'b1, 1'b1, -1, 0);
        step(2 * OS);
        check("after_break_accepts", 32'(acc[0] - a0), 32'd1);
        check("after_break_dout",    32'(last_d[0]),   32'h81);
`else
        b0 = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised successor UART receiver. Adds configurable data width, parity, stop bits and oversampling ratio. Uses 3-sample majority voting, false-start rejection, and frame/parity/overrun error reporting. Received words go out through a one-entry valid/ready holding register. Sits between the pad-side rx line and the byte consumer (FIFO or command parser), clocked by the oversampling tick domain.

Parameters:
DATA_BITS, 8, data bits per frame; legal 5..9; LSB received first
OVERSAMPLE, 16, ticks per bit period; even, legal 8..32
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits expected; legal 1 or 2

Ports:
s_tick  input  1  clock (oversampling tick); all logic on posedge
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous serial line, idle high
dout  output  DATA_BITS  received word, LSB = first data bit
dout_valid  output  1  dout/flags hold a word
dout_ready  input  1  consumer accepts word when high with dout_valid
parity_err  output  1  parity mismatch for the held word
frame_err  output  1  any stop bit voted 0 for the held word
overrun_err  output  1  one-cycle pulse: completed frame dropped because buffer full

Behaviour:
- Reset: one clock, synchronous, active-low; reset is sampled low at posedge s_tick. All outputs go to 0, the FSM goes to IDLE, counters clear, and the synchroniser presets to 1. Reset mid-frame discards the partial word.
- rx passes through a 2-flop synchroniser (rx_s). All sample positions below refer to rx_s.
- Bit counter cnt runs 0..OVERSAMPLE-1. cnt=0 is the bit-start edge. Votes are taken at cnt = M-1, M, M+1, where M = OVERSAMPLE/2. The bit value is the majority of the 3 votes.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: rx_s==0 -> START with cnt=0.
  - START: at cnt==M+1, vote==1 (false start) -> IDLE; otherwise continue. At cnt==OVERSAMPLE-1 -> DATA with cnt=0 and bit index 0.
  - DATA: at cnt==OVERSAMPLE-1, store vote into shift[idx] and increment idx. After idx DATA_BITS-1 -> PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: compute expected parity = XOR of data bits (inverted for odd). At cnt==OVERSAMPLE-1 -> STOP.
  - STOP: the first stop bit (when STOP_BITS=2) ends at cnt==OVERSAMPLE-1. The final stop bit completes early, at cnt==M+1, so the receiver can resync to a back-to-back start bit. Then -> IDLE and the frame completes.
- Frame completion (one cycle after the final vote):
  - If the buffer is empty, or dout_valid & dout_ready in that same cycle: load dout, parity_err and frame_err, and set dout_valid=1.
  - Otherwise keep the old word and flags, drop the new frame, and pulse overrun_err for 1 cycle.
- Handshake: a word is consumed on a cycle where dout_valid & dout_ready. dout_valid clears the next cycle unless a new frame completes in the same cycle. dout and flags are stable while dout_valid=1.
- Errors do not suppress delivery; the word is delivered with its flags set.

Optional Feature:
UART_RX_BREAK_DET_EN
- Defined: adds an output port break_det (1-bit). It pulses for 1 cycle when a frame has all data bits 0, parity (if any) 0, and the final stop bit voted 0. In that case the frame is NOT loaded into the buffer and no overrun is signalled. The FSM then waits in IDLE until rx_s has been 1 for OVERSAMPLE consecutive ticks before it arms start detection again.
- Undefined: break_det is absent, and a break is delivered as word 0 with frame_err=1.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum
  - PARITY_NONE, PARITY_EVEN and PARITY_ODD constants
  - a function parity_calc(data, mode)
- Sub-module uart_rx_sampler: 2-flop synchroniser plus 3-vote majority register. Inputs: s_tick, reset, rx, cnt. Outputs: rx_s, vote.

Test Plan:
1. OVERSAMPLE=16, 8N1, send 0xA5 (bits 1,0,1,0,0,1,0,1) with dout_ready=1 -> dout=0xA5, dout_valid pulses 1 cycle, parity_err=frame_err=0.
2. 8E1, send 0x07 with parity bit 0 (expected 1) -> dout=0x07, parity_err=1. Then 8O1 with 0x07 and parity 0 -> parity_err=0.
3. Low glitch on rx for 4 ticks -> FSM returns to IDLE, no dout_valid. Same glitch mid data bit of 0xFF -> majority vote still yields dout=0xFF.
4. dout_ready=0, send 0x11 then 0x22 back-to-back -> dout holds 0x11, overrun_err pulses once at 0x22 completion. Raise dout_ready in the completion cycle of a third frame 0x33 -> dout=0x33 next cycle, no overrun.
5. STOP_BITS=2, second stop bit held 0 on word 0x3C -> dout=0x3C, frame_err=1. Assert reset low mid-DATA of the next frame -> all outputs 0, next clean frame 0x5A received correctly.
6. UART_RX_BREAK_DET_EN defined, rx held low 12 bit-times -> break_det pulses once, dout_valid stays 0. After rx is high for 16 ticks, 0x81 is received normally.
